// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage pipeline: EX operand forwarding and load-use/MDU stall sequencing.
// Define HAZARD_PERF_CNT_EN to add the Stall_Cnt / Ld_Stall_Cnt performance counter ports.
module hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] Src_D,
  input  logic [NUM_SRC*REG_AW-1:0] Src_E,
  input  logic [REG_AW-1:0]         RegWrDst_E,
  input  logic                      RegWr_E,
  input  logic                      MemToReg_E,
  input  logic [REG_AW-1:0]         RegWrDst_M,
  input  logic                      RegWr_M,
  input  logic [REG_AW-1:0]         RegWrDst_W,
  input  logic                      RegWr_W,
  input  logic                      Mdu_Start_E,
  input  logic                      Mdu_Use_D,
  output logic [NUM_SRC*2-1:0]      Forward_E,
  output logic                      Stall_F,
  output logic                      Stall_D,
  output logic                      Flush_E,
  output logic                      Mdu_Busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               Stall_Cnt,
  output logic [31:0]               Ld_Stall_Cnt
`endif
);

  typedef enum logic {RUN, LD_WAIT} ld_state_t;

  ld_state_t  state;
  logic [3:0] ld_cnt;
  logic [5:0] mdu_cnt;
  logic       lu_hit;
  logic       ld_stall;
  logic       mdu_stall;
  logic       stall;

  // MEM result wins over WB; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] s);
    if (s != '0 && s == RegWrDst_M && RegWr_M)      return 2'b10;
    else if (s != '0 && s == RegWrDst_W && RegWr_W) return 2'b01;
    else                                            return 2'b00;
  endfunction

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    Forward_E = '0;
    for (int i = 0; i < NUM_SRC; i++)
      Forward_E[i*2 +: 2] = fwd_sel(Src_E[i*REG_AW +: REG_AW]);
  end

  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (Src_D[i*REG_AW +: REG_AW] == RegWrDst_E) lu_hit = 1'b1;
    lu_hit = lu_hit && MemToReg_E && RegWr_E && (RegWrDst_E != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      ld_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (lu_hit && LOAD_LAT > 1) begin
            state  <= LD_WAIT;
            ld_cnt <= 4'(LOAD_LAT - 1);
          end
        end
        LD_WAIT: begin
          ld_cnt <= ld_cnt - 4'd1;
          if (ld_cnt == 4'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // A start always reloads, so an issue while busy restarts the full latency.
  always_ff @(posedge clk) begin
    if (rst)                mdu_cnt <= '0;
    else if (Mdu_Start_E)   mdu_cnt <= 6'(MDU_LAT);
    else if (mdu_cnt != '0) mdu_cnt <= mdu_cnt - 6'd1;
  end

  assign ld_stall  = (state == RUN && lu_hit) || (state == LD_WAIT);
  assign mdu_stall = Mdu_Use_D && ((mdu_cnt != '0) || Mdu_Start_E);

  // Reset is synchronous, so the held state is masked to keep outputs quiet in the reset cycle.
  assign stall    = !rst && (ld_stall || mdu_stall);
  assign Stall_F  = stall;
  assign Stall_D  = stall;
  assign Flush_E  = stall;
  assign Mdu_Busy = !rst && (mdu_cnt != '0);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] ld_stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q    <= '0;
      ld_stall_cnt_q <= '0;
    end else begin
      if (stall)                  stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (ld_stall && !mdu_stall) ld_stall_cnt_q <= ld_stall_cnt_q + 32'd1;
    end
  end

  assign Stall_Cnt    = rst ? '0 : stall_cnt_q;
  assign Ld_Stall_Cnt = rst ? '0 : ld_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: forwarding table, directed stall sequences and
// randomized cycles compared against a cycle-index based reference model.
module tb_hazard_unit;
  localparam int MDU_LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] src_d, src_e;
  logic [4:0] dst_e, dst_m, dst_w;
  logic       reg_wr_e, mem_to_reg_e, reg_wr_m, reg_wr_w;
  logic       mdu_start_e, mdu_use_d;

  logic [3:0] fwd, fwd1;
  logic       stall_f, stall_d, flush_e, busy;
  logic       stall_f1, stall_d1, flush_e1, busy1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, ld_stall_cnt, stall_cnt1, ld_stall_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .MDU_LAT(MDU_LAT)) u_dut (
    .clk(clk), .rst(rst), .Src_D(src_d), .Src_E(src_e),
    .RegWrDst_E(dst_e), .RegWr_E(reg_wr_e), .MemToReg_E(mem_to_reg_e),
    .RegWrDst_M(dst_m), .RegWr_M(reg_wr_m), .RegWrDst_W(dst_w), .RegWr_W(reg_wr_w),
    .Mdu_Start_E(mdu_start_e), .Mdu_Use_D(mdu_use_d),
    .Forward_E(fwd), .Stall_F(stall_f), .Stall_D(stall_d), .Flush_E(flush_e),
    .Mdu_Busy(busy)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cnt(stall_cnt), .Ld_Stall_Cnt(ld_stall_cnt)
`endif
  );

  hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .MDU_LAT(MDU_LAT)) u_dut1 (
    .clk(clk), .rst(rst), .Src_D(src_d), .Src_E(src_e),
    .RegWrDst_E(dst_e), .RegWr_E(reg_wr_e), .MemToReg_E(mem_to_reg_e),
    .RegWrDst_M(dst_m), .RegWr_M(reg_wr_m), .RegWrDst_W(dst_w), .RegWr_W(reg_wr_w),
    .Mdu_Start_E(mdu_start_e), .Mdu_Use_D(mdu_use_d),
    .Forward_E(fwd1), .Stall_F(stall_f1), .Stall_D(stall_d1), .Flush_E(flush_e1),
    .Mdu_Busy(busy1)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cnt(stall_cnt1), .Ld_Stall_Cnt(ld_stall_cnt1)
`endif
  );

  // Reference model state: cycle index, end of each load window, last MDU issue cycle.
  int cyc        = 0;
  int ld_end3    = 0;
  int ld_end1    = 0;
  int last_start = -100;

  logic [3:0] got_fwd;
  logic       got_stall3, got_stall1, got_busy;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] s);
    if (s != 0 && s == dst_m && reg_wr_m)      return 2'b10;
    else if (s != 0 && s == dst_w && reg_wr_w) return 2'b01;
    else                                       return 2'b00;
  endfunction

  task automatic clear_in();
    src_d = '0; src_e = '0; dst_e = '0; dst_m = '0; dst_w = '0;
    reg_wr_e = 0; mem_to_reg_e = 0; reg_wr_m = 0; reg_wr_w = 0;
    mdu_start_e = 0; mdu_use_d = 0;
  endtask

  task automatic set_load(input logic [4:0] r);
    dst_e = r; reg_wr_e = 1; mem_to_reg_e = 1; src_d[9:5] = 5'd5;
  endtask

  // Inputs are driven just after a rising edge; outputs are sampled mid-cycle.
  task automatic step();
    logic [3:0] efwd;
    logic hit, busy_e, mst, w3, w1, s3, s1;
    #3;
    got_fwd = fwd; got_stall3 = stall_f; got_stall1 = stall_f1; got_busy = busy;
    efwd = {exp_fwd(src_e[9:5]), exp_fwd(src_e[4:0])};
    if (rst) begin
      s3 = 0; s1 = 0; busy_e = 0;
      ld_end3 = 0; ld_end1 = 0; last_start = -100;
    end else begin
      hit = mem_to_reg_e && reg_wr_e && dst_e != 0 &&
            (src_d[4:0] == dst_e || src_d[9:5] == dst_e);
      busy_e = (cyc > last_start) && (cyc <= last_start + MDU_LAT);
      mst = mdu_use_d && (busy_e || mdu_start_e);
      w3 = cyc < ld_end3;
      w1 = cyc < ld_end1;
      if (!w3 && hit) ld_end3 = cyc + 3;
      if (!w1 && hit) ld_end1 = cyc + 1;
      s3 = w3 || hit || mst;
      s1 = w1 || hit || mst;
      if (mdu_start_e) last_start = cyc;
    end
    check("fwd", fwd, efwd);
    check("fwd_lat1", fwd1, efwd);
    check("stall_lat3", {stall_f, stall_d, flush_e}, {3{s3}});
    check("stall_lat1", {stall_f1, stall_d1, flush_e1}, {3{s1}});
    check("busy", busy, busy_e);
    check("busy_lat1", busy1, busy_e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] s0, s1, m; logic wm; logic [4:0] w; logic ww; logic [3:0] exp;
  } fwd_vec_t;

  fwd_vec_t fv[7];

  initial begin
    int n_stall, n_busy;
    bit b3[4];
    bit b1[4];

    fv[0] = '{5'd3, 5'd0, 5'd3, 1'b1, 5'd3, 1'b1, 4'b0010};
    fv[1] = '{5'd3, 5'd0, 5'd3, 1'b0, 5'd3, 1'b1, 4'b0001};
    fv[2] = '{5'd0, 5'd0, 5'd3, 1'b1, 5'd3, 1'b1, 4'b0000};
    fv[3] = '{5'd3, 5'd7, 5'd7, 1'b1, 5'd3, 1'b1, 4'b1001};
    fv[4] = '{5'd4, 5'd4, 5'd5, 1'b1, 5'd4, 1'b0, 4'b0000};
    fv[5] = '{5'd9, 5'd9, 5'd9, 1'b0, 5'd9, 1'b1, 4'b0101};
    fv[6] = '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 4'b0000};
    b3 = '{1, 1, 1, 0};
    b1 = '{1, 0, 0, 0};

    clear_in();
    rst = 1;
    @(posedge clk); #1;
    step();
    check("reset_stall", {got_stall3, got_stall1}, 0);
    check("reset_busy", got_busy, 0);
    rst = 0;

    // Forwarding priority table, exercised while in reset too (forwarding ignores rst).
    for (int i = 0; i < 7; i++) begin
      clear_in();
      src_e = {fv[i].s1, fv[i].s0};
      dst_m = fv[i].m; reg_wr_m = fv[i].wm; dst_w = fv[i].w; reg_wr_w = fv[i].ww;
      rst = (i == 6);
      step();
      check("fwd_table", got_fwd, fv[i].exp);
    end
    rst = 0;
    clear_in();
    step();

    // Load-use: one-cycle load in EX, both latencies observed side by side.
    for (int i = 0; i < 4; i++) begin
      clear_in();
      if (i == 0) set_load(5'd5);
      step();
      check("ld_seq_lat3", got_stall3, b3[i]);
      check("ld_seq_lat1", got_stall1, b1[i]);
    end

    clear_in(); set_load(5'd0); step();
    check("ld_r0_nostall", got_stall3, 0);
    clear_in(); set_load(5'd5); mem_to_reg_e = 0; step();
    check("ld_notload_nostall", got_stall3, 0);
    clear_in(); step();

    // MDU issue with a dependent held in ID.
    n_stall = 0; n_busy = 0;
    clear_in(); mdu_use_d = 1; mdu_start_e = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      mdu_start_e = 0;
      n_stall += int'(got_stall3);
      n_busy  += int'(got_busy);
    end
    check("mdu_stall_cycles", n_stall, 5);
    check("mdu_busy_cycles", n_busy, 4);

    // Restart while the count is 2: busy must run 4 more cycles.
    clear_in(); mdu_start_e = 1; step();
    mdu_start_e = 0; step(); step();
    mdu_start_e = 1; step();
    mdu_start_e = 0;
    n_busy = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_busy += int'(got_busy);
    end
    check("mdu_restart_busy", n_busy, 4);

    // Load-use arriving while the MDU stall is pending: stall spans until MDU clears.
    clear_in(); mdu_use_d = 1; mdu_start_e = 1; step();
    mdu_start_e = 0; set_load(5'd5);
    n_stall = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      src_d = '0; dst_e = '0; reg_wr_e = 0; mem_to_reg_e = 0;
      n_stall += int'(got_stall3);
    end
    check("combo_stall_cycles", n_stall, 4);
    check("combo_busy_end", got_busy, 0);

    // Reset while in LD_WAIT.
    clear_in(); set_load(5'd5); step();
    clear_in(); rst = 1; step();
    check("rst_ldwait_stall", got_stall3, 0);
    check("rst_ldwait_busy", got_busy, 0);
    rst = 0; step();
    check("after_rst_stall", got_stall3, 0);
    step();
    check("after_rst_stall2", got_stall3, 0);

`ifdef HAZARD_PERF_CNT_EN
    clear_in(); rst = 1; step(); rst = 0;
    set_load(5'd5); step();
    clear_in(); step(); step(); step();
    mdu_use_d = 1; mdu_start_e = 1; step();
    mdu_start_e = 0; step(); step(); step();
    mdu_use_d = 0;
    for (int i = 0; i < 6; i++) step();
    check("perf_stall_cnt", stall_cnt, 7);
    check("perf_ld_stall_cnt", ld_stall_cnt, 3);
`endif

    // Randomized cycles against the model; small address range to force hits.
    clear_in();
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      src_d        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      src_e        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      dst_e        = 5'($urandom_range(0, 3));
      dst_m        = 5'($urandom_range(0, 3));
      dst_w        = 5'($urandom_range(0, 3));
      reg_wr_e     = 1'($urandom_range(0, 1));
      mem_to_reg_e = ($urandom_range(0, 2) == 0);
      reg_wr_m     = 1'($urandom_range(0, 1));
      reg_wr_w     = 1'($urandom_range(0, 1));
      mdu_start_e  = ($urandom_range(0, 7) == 0);
      mdu_use_d    = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
